// File: rtl/shift_exec_if.sv
// Handshake bundle for the shift/rotate execution stage.
// Upstream (master) drives operations and consumes results; the stage is the slave.
interface shift_exec_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_op, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_op, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_neg
  );
endinterface

// File: rtl/shift_exec_stage.sv
// Two-deep registered shift/rotate stage: S1 captures the operation, S2 holds
// the result and flags. Every shift variant is built from one right-rotator
// followed by a mask (logical) or sign fill (arithmetic).
module shift_exec_stage #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  shift_exec_if.slave bus
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  logic             s1_valid;
  shift_op_e        s1_op;
  logic [WIDTH-1:0] s1_data;
  logic [AMT_W-1:0] s1_amt;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_carry;
  logic             s2_zero;
  logic             s2_neg;

  logic             s2_load;
  logic             s1_load;

  logic [AMT_W-1:0] rot_amt;
  logic [WIDTH-1:0] rotated;
  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] lo_mask;
  logic [WIDTH-1:0] result;
  logic             carry;

  // S2 advances when it is empty or being drained; S1 may refill in the same cycle.
  always_comb begin
    s2_load = s1_valid && (!s2_valid || bus.out_ready);
    s1_load = !s1_valid || s2_load;
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_carry = s2_carry;
  assign bus.out_zero  = s2_zero;
  assign bus.out_neg   = s2_neg;

  // Shared rotator plus per-op masking; left shift is a right rotate by -amt.
  always_comb begin
    rot_amt = s1_amt;
    result  = '0;
    carry   = 1'b0;
    if (s1_op == OP_SLL) begin
      rot_amt = ~s1_amt + AMT_W'(1);
    end
    rotated = WIDTH'({s1_data, s1_data} >> rot_amt);
    hi_mask = ~({WIDTH{1'b1}} >> s1_amt);
    lo_mask = ~({WIDTH{1'b1}} << s1_amt);
    case (s1_op)
      OP_SLL: begin
        result = rotated & ~lo_mask;
        carry  = s1_data[rot_amt];
      end
      OP_SRL: begin
        result = rotated & ~hi_mask;
        carry  = s1_data[s1_amt - AMT_W'(1)];
      end
      OP_SRA: begin
        result = (rotated & ~hi_mask) | ({WIDTH{s1_data[WIDTH-1]}} & hi_mask);
        carry  = s1_data[s1_amt - AMT_W'(1)];
      end
      default: begin
        result = rotated;
        carry  = rotated[WIDTH-1];
      end
    endcase
    if (s1_amt == '0) begin
      carry = 1'b0;
    end
  end

  // S1: capture a new operation whenever the slot is free or being vacated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_SLL;
      s1_data  <= '0;
      s1_amt   <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op   <= shift_op_e'(bus.in_op);
        s1_data <= bus.in_data;
        s1_amt  <= bus.in_amt;
      end
    end
  end

  // S2: result and flags load together; they hold while stalled or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_carry <= 1'b0;
      s2_zero  <= 1'b0;
      s2_neg   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_data  <= result;
      s2_carry <= carry;
      s2_zero  <= (result == '0);
      s2_neg   <= result[WIDTH-1];
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed and stream tests for the shift/rotate execution stage.
module tb_shift_exec_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_exec_if bus ();

  shift_exec_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (got running, required finish)");
    $fatal(1);
  end

  // Independent reference: plain shift operators and a bit-serial rotate.
  function automatic logic [16:0] ref_op(input logic [1:0] op, input logic [15:0] d,
                                         input logic [3:0] a);
    logic [15:0] r;
    logic        c;
    r = d;
    c = 1'b0;
    case (op)
      2'b00: begin
        r = d << a;
        if (a != 0) c = d[16 - int'(a)];
      end
      2'b01: begin
        r = d >> a;
        if (a != 0) c = d[int'(a) - 1];
      end
      2'b10: begin
        r = $signed(d) >>> a;
        if (a != 0) c = d[int'(a) - 1];
      end
      default: begin
        for (int k = 0; k < int'(a); k++) begin
          c = r[0];
          r = {r[0], r[15:1]};
        end
      end
    endcase
    return {c, r};
  endfunction

  // Directed vectors: op, operand, amount, hand-computed result and carry.
  logic [1:0]  v_op  [12] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01,
                              2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};
  logic [15:0] v_d   [12] = '{16'h8000, 16'h8000, 16'h00F1, 16'h8001, 16'h1234, 16'h1234,
                              16'h1234, 16'h1234, 16'h00F0, 16'h0001, 16'h0001, 16'h000F};
  logic [3:0]  v_a   [12] = '{4'd15, 4'd15, 4'd4, 4'd1, 4'd0, 4'd0,
                              4'd0, 4'd0, 4'd4, 4'd1, 4'd4, 4'd4};
  logic [15:0] v_res [12] = '{16'hFFFF, 16'h0001, 16'h0F10, 16'h0002, 16'h1234, 16'h1234,
                              16'h1234, 16'h1234, 16'h000F, 16'h0000, 16'h1000, 16'hF000};
  logic        v_c   [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Stall vectors (hand-computed).
  logic [1:0]  s_op  [3] = '{2'b11, 2'b00, 2'b10};
  logic [15:0] s_d   [3] = '{16'h1234, 16'h0F0F, 16'h8421};
  logic [3:0]  s_a   [3] = '{4'd4, 4'd8, 4'd2};
  logic [15:0] s_res [3] = '{16'h4123, 16'h0F00, 16'hE108};
  logic        s_c   [3] = '{1'b0, 1'b1, 1'b0};

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_data   = 16'h0000;
    bus.in_amt    = 4'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_carry !== 1'b0 ||
        bus.out_zero !== 1'b0 || bus.out_neg !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%b z=%b n=%b, required all zero",
               bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_neg);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    $display("reset released: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_ror_latency();
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = 2'b11;
    bus.in_data   = 16'h8001;
    bus.in_amt    = 4'd1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ror_latency_1cyc: out_valid got %b, required 0", bus.out_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hC000 || bus.out_carry !== 1'b1 ||
        bus.out_neg !== 1'b1 || bus.out_zero !== 1'b0) begin
      bad++;
      $display("FAIL ror_latency_2cyc: got v=%b d=%h c=%b z=%b n=%b, required v=1 d=c000 c=1 z=0 n=1",
               bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_neg);
    end
    $display("txn ROR 8001 amt=1 -> d=%h c=%b z=%b n=%b", bus.out_data, bus.out_carry,
             bus.out_zero, bus.out_neg);
  endtask

  task automatic test_directed();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_op     = v_op[i];
      bus.in_data   = v_d[i];
      bus.in_amt    = v_a[i];
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== v_res[i] || bus.out_carry !== v_c[i] ||
          bus.out_zero !== (v_res[i] == 16'h0) || bus.out_neg !== v_res[i][15]) begin
        bad++;
        $display("FAIL directed_%0d: got v=%b d=%h c=%b z=%b n=%b, required v=1 d=%h c=%b z=%b n=%b",
                 i, bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_neg,
                 v_res[i], v_c[i], (v_res[i] == 16'h0), v_res[i][15]);
      end
      $display("txn op=%0d d=%h amt=%0d -> d=%h c=%b z=%b n=%b", v_op[i], v_d[i], v_a[i],
               bus.out_data, bus.out_carry, bus.out_zero, bus.out_neg);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  b_op [8];
    logic [15:0] b_d  [8];
    logic [3:0]  b_a  [8];
    logic [16:0] exp;
    int sent, got, first_cyc, last_cyc;
    for (int i = 0; i < 8; i++) begin
      b_op[i] = 2'($urandom_range(0, 3));
      b_d[i]  = 16'($urandom);
      b_a[i]  = 4'($urandom_range(0, 15));
    end
    sent = 0; got = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 20 && got < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.in_op    = b_op[sent];
        bus.in_data  = b_d[sent];
        bus.in_amt   = b_a[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid === 1'b1) begin
        exp = ref_op(b_op[got], b_d[got], b_a[got]);
        total++;
        if (bus.out_data !== exp[15:0] || bus.out_carry !== exp[16] ||
            bus.out_zero !== (exp[15:0] == 16'h0) || bus.out_neg !== exp[15]) begin
          bad++;
          $display("FAIL stream_%0d: got d=%h c=%b z=%b n=%b, required d=%h c=%b z=%b n=%b",
                   got, bus.out_data, bus.out_carry, bus.out_zero, bus.out_neg,
                   exp[15:0], exp[16], (exp[15:0] == 16'h0), exp[15]);
        end
        $display("txn stream op=%0d d=%h amt=%0d -> d=%h c=%b", b_op[got], b_d[got],
                 b_a[got], bus.out_data, bus.out_carry);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      if (sent < 8) begin
        total++;
        if (bus.in_ready !== 1'b1) begin
          bad++;
          $display("FAIL stream_in_ready: cycle %0d got %b, required 1", cyc, bus.in_ready);
        end
        if (bus.in_ready === 1'b1) sent++;
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (got != 8 || (last_cyc - first_cyc) != 7 || first_cyc != 2) begin
      bad++;
      $display("FAIL stream_rate: got %0d results first=%0d span=%0d, required 8 first=2 span=7",
               got, first_cyc, last_cyc - first_cyc);
    end
  endtask

  task automatic test_stall();
    int idx, got;
    logic        seen;
    logic [15:0] held_d;
    logic        held_c;
    idx = 0; got = 0; seen = 1'b0; held_d = '0; held_c = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = (idx < 3);
      bus.in_op     = s_op[idx < 3 ? idx : 2];
      bus.in_data   = s_d[idx < 3 ? idx : 2];
      bus.in_amt    = s_a[idx < 3 ? idx : 2];
      #1;
      if (bus.out_valid === 1'b1) begin
        if (!seen) begin
          seen   = 1'b1;
          held_d = bus.out_data;
          held_c = bus.out_carry;
        end else begin
          total++;
          if (bus.out_data !== held_d || bus.out_carry !== held_c) begin
            bad++;
            $display("FAIL stall_hold: got d=%h c=%b, required d=%h c=%b",
                     bus.out_data, bus.out_carry, held_d, held_c);
          end
        end
      end
      if (bus.in_valid && bus.in_ready === 1'b1) idx++;
    end
    total++;
    if (idx != 2 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept: got accepted=%0d in_ready=%b, required accepted=2 in_ready=0",
               idx, bus.in_ready);
    end
    total++;
    if (held_d !== s_res[0]) begin
      bad++;
      $display("FAIL stall_head: got d=%h, required %h", held_d, s_res[0]);
    end
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (idx < 3);
      bus.in_op     = s_op[idx < 3 ? idx : 2];
      bus.in_data   = s_d[idx < 3 ? idx : 2];
      bus.in_amt    = s_a[idx < 3 ? idx : 2];
      #1;
      if (bus.out_valid === 1'b1) begin
        total++;
        if (bus.out_data !== s_res[got] || bus.out_carry !== s_c[got]) begin
          bad++;
          $display("FAIL stall_drain_%0d: got d=%h c=%b, required d=%h c=%b",
                   got, bus.out_data, bus.out_carry, s_res[got], s_c[got]);
        end
        $display("txn drain %0d -> d=%h c=%b", got, bus.out_data, bus.out_carry);
        got++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) idx++;
    end
    bus.in_valid = 1'b0;
    total++;
    if (got != 3) begin
      bad++;
      $display("FAIL stall_count: got %0d results, required 3", got);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = 2'b11;
    bus.in_data   = 16'h8001;
    bus.in_amt    = 4'd1;
    @(negedge clk);
    bus.in_data = 16'h0F0F;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_neg !== 1'b1) begin
      bad++;
      $display("FAIL midflight_full: got v=%b in_ready=%b n=%b, required v=1 in_ready=0 n=1",
               bus.out_valid, bus.in_ready, bus.out_neg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_carry !== 1'b0 ||
        bus.out_zero !== 1'b0 || bus.out_neg !== 1'b0) begin
      bad++;
      $display("FAIL midflight_async: got v=%b d=%h c=%b z=%b n=%b, required all zero",
               bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_neg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midflight_stale: cycle %0d out_valid got %b, required 0",
                 cyc, bus.out_valid);
      end
    end
    $display("txn reset mid-flight -> out_valid=%b", bus.out_valid);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_ror_latency();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
